// File: rtl/fbuf_pkg.sv
// Shared constants, FSM state type and depth helper for the framebuffer
// write scheduler.
package fbuf_pkg;

    localparam int FBUF_ADDR_W  = 17;
    localparam int FBUF_COLOR_W = 12;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } fbuf_state_e;

    // Number of framebuffer words for a downscaled frame.
    function automatic int fbuf_depth(input int width, input int height, input int scale);
        return (width / scale) * (height / scale);
    endfunction

endpackage

// File: rtl/fbuf_rr_arbiter.sv
// Two-input round-robin arbiter. The grant is combinational from the
// request vector; the pointer remembers the last winner and only moves
// when a grant is actually issued (grant implies transfer upstream).
module fbuf_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    // 1 means requester 1 won last, so requester 0 wins the next tie.
    logic last_q;

    // Pick a winner: lone requester wins, ties go to the one not served last.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Advance the pointer only when somebody was granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (|grant) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/fbuf_write_scheduler.sv
// Framebuffer write scheduler: arbitrates two pixel writers onto one
// framebuffer write port and optionally sweeps the whole buffer with a
// fill color. The clear engine is built only when FBUF_CLEAR_EN is defined;
// otherwise the clear ports are inert and the FSM never leaves ARB.
module fbuf_write_scheduler
    import fbuf_pkg::*;
#(
    parameter int FRAME_WIDTH    = 1920,
    parameter int FRAME_HEIGHT   = 1080,
    parameter int SCALING_FACTOR = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [FBUF_ADDR_W-1:0]  req0_address,
    input  logic [FBUF_COLOR_W-1:0] req0_color,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [FBUF_ADDR_W-1:0]  req1_address,
    input  logic [FBUF_COLOR_W-1:0] req1_color,
    input  logic                    clear_start,
    input  logic [FBUF_COLOR_W-1:0] clear_color,
    output logic                    clear_busy,
    output logic                    clear_done,
    output logic [FBUF_ADDR_W-1:0]  pixel_fbuf_address,
    output logic [FBUF_COLOR_W-1:0] pixel_fbuf_color,
    output logic                    pixel_fbuf_wr_en,
    output logic                    addr_err
);

    localparam int DEPTH = fbuf_depth(FRAME_WIDTH, FRAME_HEIGHT, SCALING_FACTOR);
    localparam logic [FBUF_ADDR_W-1:0] LAST_ADDR = FBUF_ADDR_W'(DEPTH - 1);

    fbuf_state_e             state_q;
    logic [FBUF_ADDR_W-1:0]  addr_q;
    logic [FBUF_COLOR_W-1:0] color_q;
    logic                    wr_en_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic [1:0]              grant;
    logic                    arb_en;
    logic [FBUF_ADDR_W-1:0]  sel_addr;
    logic [FBUF_COLOR_W-1:0] sel_color;
    logic                    in_range;

`ifdef FBUF_CLEAR_EN
    logic [FBUF_ADDR_W-1:0]  cnt_q;
    logic [FBUF_COLOR_W-1:0] fill_color_q;
    logic                    clear_go;

    // A clear request steals the cycle: no requester is accepted alongside it.
    assign clear_go = (state_q == ST_ARB) && clear_start;
    assign arb_en   = (state_q == ST_ARB) && !clear_start;
`else
    logic unused_clear;
    assign unused_clear = ^{clear_start, clear_color};
    assign arb_en       = (state_q == ST_ARB);
`endif

    fbuf_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({req1_valid, req0_valid}),
        .en    (arb_en),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign sel_addr   = grant[1] ? req1_address : req0_address;
    assign sel_color  = grant[1] ? req1_color   : req0_color;
    assign in_range   = (32'(sel_addr) < 32'(DEPTH));

    // Scheduler FSM with registered write port and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ARB;
            addr_q       <= '0;
            color_q      <= '0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef FBUF_CLEAR_EN
            cnt_q        <= '0;
            fill_color_q <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_ARB: begin
`ifdef FBUF_CLEAR_EN
                    if (clear_go) begin
                        state_q      <= ST_CLEAR;
                        fill_color_q <= clear_color;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                    end else
`endif
                    if (|grant) begin
                        // Out-of-range writes are swallowed; the port keeps
                        // showing the last good write.
                        if (in_range) begin
                            addr_q  <= sel_addr;
                            color_q <= sel_color;
                            wr_en_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
`ifdef FBUF_CLEAR_EN
                ST_CLEAR: begin
                    addr_q  <= cnt_q;
                    color_q <= fill_color_q;
                    wr_en_q <= 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_ARB;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                default: state_q <= ST_ARB;
            endcase
        end
    end

    assign pixel_fbuf_address = addr_q;
    assign pixel_fbuf_color   = color_q;
    assign pixel_fbuf_wr_en   = wr_en_q;
    assign clear_busy         = busy_q;
    assign clear_done         = done_q;
    assign addr_err           = err_q;

endmodule

// File: tb/tb_fbuf_write_scheduler.sv
// Self-checking bench for fbuf_write_scheduler using a reduced frame
// (64x32 scaled by 4 -> 128 words) so full sweeps stay short. Works in both
// builds: with FBUF_CLEAR_EN the sweep is checked, without it clear_start
// must have no effect.
module tb_fbuf_write_scheduler;

    localparam int W     = 64;
    localparam int H     = 32;
    localparam int S     = 4;
    localparam int DEPTH = (W / S) * (H / S);
`ifdef FBUF_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [16:0] req0_address = '0, req1_address = '0;
    logic [11:0] req0_color = '0, req1_color = '0;
    logic        clear_start = 1'b0;
    logic [11:0] clear_color = '0;
    logic        clear_busy, clear_done;
    logic [16:0] pixel_fbuf_address;
    logic [11:0] pixel_fbuf_color;
    logic        pixel_fbuf_wr_en;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    // Reference model: output registers as the framebuffer port should look.
    bit m_clear;
    int m_last;
    int m_idx;
    int m_ccolor;
    int e_addr, e_color;
    bit e_wr, e_busy, e_done, e_err;

    fbuf_write_scheduler #(
        .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .SCALING_FACTOR(S)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_address(req0_address), .req0_color(req0_color),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_address(req1_address), .req1_color(req1_color),
        .clear_start(clear_start), .clear_color(clear_color),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .pixel_fbuf_address(pixel_fbuf_address),
        .pixel_fbuf_color(pixel_fbuf_color),
        .pixel_fbuf_wr_en(pixel_fbuf_wr_en),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("wr_en", pixel_fbuf_wr_en, e_wr);
        check("address", pixel_fbuf_address, e_addr);
        check("color", pixel_fbuf_color, e_color);
        check("clear_busy", clear_busy, e_busy);
        check("clear_done", clear_done, e_done);
        check("addr_err", addr_err, e_err);
    endtask

    task automatic model_reset();
        m_clear = 0; m_last = 1; m_idx = 0; m_ccolor = 0;
        e_addr = 0; e_color = 0; e_wr = 0; e_busy = 0; e_done = 0; e_err = 0;
    endtask

    // Asynchronous reset: outputs must clear without waiting for an edge.
    task automatic apply_reset();
        req0_valid = 0; req1_valid = 0; clear_start = 0;
        #1; rst = 1'b1; #1;
        model_reset();
        check_outputs();
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check readys mid-cycle, advance the
    // model, check the registered outputs just after the edge.
    task automatic step(input logic v0, input logic [16:0] a0, input logic [11:0] c0,
                        input logic v1, input logic [16:0] a1, input logic [11:0] c1,
                        input logic cs, input logic [11:0] cc,
                        output int g, output logic [1:0] rdy);
        int  exp_g;
        bit  start;
        int  a, c;
        req0_valid = v0; req0_address = a0; req0_color = c0;
        req1_valid = v1; req1_address = a1; req1_color = c1;
        clear_start = cs; clear_color = cc;
        #4;
        exp_g = -1;
        start = 0;
        if (!m_clear) begin
            if (CLR_EN && cs) start = 1;
            else if (v0 && v1) exp_g = (m_last == 0) ? 1 : 0;
            else if (v0) exp_g = 0;
            else if (v1) exp_g = 1;
        end
        rdy = {req1_ready, req0_ready};
        check("req0_ready", req0_ready, exp_g == 0);
        check("req1_ready", req1_ready, exp_g == 1);
        g = exp_g;
        e_wr = 0;
        e_done = 0;
        if (m_clear) begin
            e_wr = 1; e_addr = m_idx; e_color = m_ccolor;
            if (m_idx == DEPTH - 1) begin
                e_done = 1; m_clear = 0; e_busy = 0;
            end
            m_idx++;
        end else if (start) begin
            m_clear = 1; m_idx = 0; m_ccolor = cc; e_busy = 1;
            $display("txn clear_start color=%03h", cc);
        end else if (exp_g >= 0) begin
            m_last = exp_g;
            a = (exp_g == 1) ? a1 : a0;
            c = (exp_g == 1) ? c1 : c0;
            if (a < DEPTH) begin
                e_wr = 1; e_addr = a; e_color = c;
                $display("txn req%0d addr=%0d color=%03h", exp_g, a, c);
            end else begin
                e_err = 1;
                $display("txn req%0d addr=%0d out of range", exp_g, a);
            end
        end
        @(posedge clk); #1;
        check_outputs();
    endtask

    initial begin : main
        int g;
        logic [1:0] rdy;
        logic [1:0] rr_exp [4];
        int n_wr, n_done;
        bit p0, p1;
        logic [16:0] pa0, pa1;
        logic [11:0] pc0, pc1;
        logic cs;

        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

        apply_reset();

        // Single requester, single write, one cycle latency.
        step(1, 17'd5, 12'hF00, 0, 0, 0, 0, 0, g, rdy);
        check("t023_ready", rdy, 2'b01);
        check("t023_wr", pixel_fbuf_wr_en, 1);
        check("t023_addr", pixel_fbuf_address, 5);
        check("t023_color", pixel_fbuf_color, 12'hF00);
        step(0, 0, 0, 0, 0, 0, 0, 0, g, rdy);
        check("hold_addr", pixel_fbuf_address, 5);

        // Tie after reset: requester 0 first, then alternate.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, 17'(10 + k), 12'h111, 1, 17'(60 + k), 12'h222, 0, 0, g, rdy);
            check("rr_grant", rdy, rr_exp[k]);
            check("rr_wr", pixel_fbuf_wr_en, 1);
        end

        // Out-of-range address is consumed and sets a sticky error.
        step(0, 0, 0, 1, 17'(DEPTH), 12'h0F0, 0, 0, g, rdy);
        check("oor_ready", rdy, 2'b10);
        check("oor_wr", pixel_fbuf_wr_en, 0);
        check("oor_err", addr_err, 1);
        for (int k = 0; k < 3; k++) step(1, 17'(k), 12'h333, 0, 0, 0, 0, 0, g, rdy);
        check("err_sticky", addr_err, 1);
        apply_reset();
        check("err_cleared", addr_err, 0);

`ifdef FBUF_CLEAR_EN
        // Full sweep while both requesters keep asking.
        n_wr = 0; n_done = 0;
        step(1, 17'd7, 12'h777, 1, 17'd8, 12'h888, 1, 12'h00F, g, rdy);
        check("clr_start_ready", rdy, 2'b00);
        for (int k = 0; k < DEPTH + 2; k++) begin
            step(1, 17'd7, 12'h777, 1, 17'd8, 12'h888, (k == 9), 12'hFFF, g, rdy);
            if (k < DEPTH) begin
                n_wr += int'(pixel_fbuf_wr_en);
                if (pixel_fbuf_color == 12'h00F) n_wr += 0;
            end
            if (clear_done) begin
                n_done++;
                check("done_addr", pixel_fbuf_address, DEPTH - 1);
            end
        end
        check("sweep_writes", n_wr, DEPTH);
        check("sweep_dones", n_done, 1);
`else
        // Clear requests have no effect in this build.
        step(1, 17'd3, 12'h123, 0, 0, 0, 1, 12'h00F, g, rdy);
        check("noclr_ready", rdy, 2'b01);
        check("noclr_busy", clear_busy, 0);
        check("noclr_addr", pixel_fbuf_address, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, g, rdy);
        check("noclr_idle_wr", pixel_fbuf_wr_en, 0);
`endif

        // Randomized traffic; requests are held until accepted.
        p0 = 0; p1 = 0; pa0 = 0; pa1 = 0; pc0 = 0; pc1 = 0;
        for (int k = 0; k < 500; k++) begin
            if (!p0 && ($urandom_range(0, 2) == 0)) begin
                p0 = 1;
                pa0 = ($urandom_range(0, 19) == 0) ? 17'(DEPTH + $urandom_range(0, 3))
                                                   : 17'($urandom_range(0, DEPTH - 1));
                pc0 = 12'($urandom);
            end
            if (!p1 && ($urandom_range(0, 2) == 0)) begin
                p1 = 1;
                pa1 = ($urandom_range(0, 19) == 0) ? 17'(DEPTH + $urandom_range(0, 3))
                                                   : 17'($urandom_range(0, DEPTH - 1));
                pc1 = 12'($urandom);
            end
            cs = ($urandom_range(0, 99) == 0);
            step(p0, pa0, pc0, p1, pa1, pc1, cs, 12'($urandom), g, rdy);
            if (g == 0) p0 = 0;
            if (g == 1) p1 = 0;
        end

`ifdef FBUF_CLEAR_EN
        // Reset mid-sweep abandons it; a second clear_start is ignored.
        apply_reset();
        step(0, 0, 0, 0, 0, 0, 1, 12'h3C3, g, rdy);
        for (int k = 0; k < DEPTH; k++) begin
            if (m_idx == 50) break;
            step(1, 17'd9, 12'h999, 0, 0, 0, (m_idx == 20), 12'hABC, g, rdy);
            check("sweep_color", pixel_fbuf_color, 12'h3C3);
        end
        check("sweep_reached", m_idx, 50);
        apply_reset();
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0, 0, g, rdy);
        step(0, 0, 0, 1, 17'd42, 12'h5A5, 0, 0, g, rdy);
        check("post_rst_grant", rdy, 2'b10);
        check("post_rst_addr", pixel_fbuf_address, 42);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
